bd_word_arbiter: RTL and testbench
==================================

Name: bd_word_arbiter

Overview:
- Round-robin arbiter that shares the single 34-bit BD word channel feeding the BD decoder among NUM_IN upstream word sources (e.g. multiple BD links or a host-injection path).
- Grants one source per transfer with a bounded burst lock, so a streaming source keeps consecutive words together without starving the others.
- Output is one registered stage: the decoder sees a clean valid/data pair, plus the index of the source that supplied each word.

Parameters:
- NUM_IN, 4, number of requesting word channels (2..16).
- N, 34, word width in bits.
- MAX_BURST, 4, maximum consecutive words granted to one source while others are waiting (1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- in_v  input  NUM_IN  per-source valid.
- in_d  input  NUM_IN*N  per-source word; source i occupies bits [i*N +: N].
- in_a  output  NUM_IN  per-source ack; a transfer occurs on a rising clk edge where in_v[i] and in_a[i] are both high.
- out_v  output  1  registered word valid toward the decoder.
- out_d  output  N  registered word.
- out_src  output  clog2(NUM_IN)  index of the source of the word currently in out_d.
- out_a  input  1  decoder ack; a transfer occurs on an edge where out_v and out_a are both high.

Behaviour:
- Reset (reset low, asynchronous): out_v=0, out_d=0, out_src=0, ptr=NUM_IN-1, cnt=0. in_a is forced to 0 while reset is low.
- Load condition: load = !out_v || out_a.
  - Full throughput: one word per cycle when out_a is held high.
- Grant g is computed combinationally each cycle:
  - Hold: if cnt!=0, cnt<MAX_BURST and in_v[ptr], then g=ptr.
  - Otherwise: g is the first i with in_v[i], scanning ptr+1, ptr+2, ... with wrap, ptr last.
  - None: if no in_v is high, there is no grant.
- Acks: in_a[i] = load && grant valid && (i==g). At most one in_a bit is high. in_a may depend combinationally on out_a. No combinational path exists from in_d to any output.
- On an edge with load and a valid grant:
  - Capture: out_d<=in_d[g], out_src<=g, out_v<=1, ptr<=g.
  - Counter: cnt<=cnt+1 on a hold, else cnt<=1.
- On an edge with load and no valid grant: out_v<=0, cnt<=0; ptr is unchanged.
- No load (out_v && !out_a): all state holds, out_d and out_src stay stable, and all in_a are 0.
- Latency: a word acked at edge k is presented on out_v/out_d in the cycle after edge k.
- Burst end: when cnt==MAX_BURST, the next grant goes to the next valid source after ptr. If no other source is valid, the same source is re-granted with cnt<=1, so a lone source is never stalled.
- Source drops valid mid-burst: its burst ends and the scan proceeds from ptr+1.
- Simultaneous drain and load: out_a and the new grant on the same edge replace the word, with no bubble.
- Reset mid-transfer: any registered word is discarded, no ack is issued, and arbitration restarts at source 0.

Test Plan:
1. Reset, then only source 2 valid, 6 words D0..D5, out_a=1 -> out_d sequence D0..D5 on consecutive cycles, out_src=2; the burst re-grants after word 4 with no gap.
2. All 4 sources always valid, MAX_BURST=4, out_a=1 -> out_src pattern 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...
3. MAX_BURST=1, sources 0 and 3 valid -> out_src alternates 0,3,0,3; no word is lost or duplicated (scoreboard per source).
4. out_a held low for 5 cycles with out_v=1 -> out_d and out_src stable, all in_a=0; on release, the next word follows on the next cycle.
5. Source 1 drops in_v after 2 words of a burst while source 2 is valid -> the next grant is to 2, cnt restarts at 1.
6. Assert reset while out_v=1 -> out_v=0 immediately (asynchronous); after release, the first grant goes to the lowest-index valid source.

Source files
------------

// File: rtl/bd_word_arbiter.sv
// bd_word_arbiter: round-robin arbiter with a bounded burst lock.
// It shares the single BD word channel that feeds the BD decoder among
// NUM_IN upstream word sources and adds one registered output stage.
//
// Handshake: every channel uses valid/ack. A word moves on a rising clk
// edge where the producer's valid and the consumer's ack are both high.
// A producer keeps its word stable while valid is high and unacked. Here,
// in_a is asserted only for the granted source, and only when the output
// register can take a word on this edge.
module bd_word_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int N         = 34,
  parameter int MAX_BURST = 4,
  localparam int SW       = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_IN-1:0]   in_v,
  input  logic [NUM_IN*N-1:0] in_d,
  output logic [NUM_IN-1:0]   in_a,
  output logic                out_v,
  output logic [N-1:0]        out_d,
  output logic [SW-1:0]       out_src,
  input  logic                out_a
);

  // Burst counter width. It must hold values 0..MAX_BURST.
  localparam int            CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [SW-1:0] PTR_RST   = SW'(NUM_IN - 1);

  // ptr is the last granted source. cnt counts consecutive words from it.
  // cnt is 0 after an idle edge, so the next grant is always a fresh scan.
  logic [SW-1:0] ptr;
  logic [CW-1:0] cnt;

  logic          load;
  logic          hold;
  logic          scan_v;
  logic [SW-1:0] scan_idx;
  logic          gnt_v;
  logic [SW-1:0] gnt;
  logic [N-1:0]  gnt_word;

  // The output register can take a word when it is empty or being drained.
  assign load = !out_v || out_a;

  // The burst continues while it is under its limit and the owner still has data.
  assign hold = (cnt != '0) && (cnt < BURST_MAX) && in_v[ptr];

  // Round-robin scan: ptr+1, ptr+2, ... with wrap, and ptr itself last.
  // Putting ptr last lets a lone source be re-granted at the burst end without a stall.
  always_comb begin
    int j;
    j        = 0;
    scan_v   = 1'b0;
    scan_idx = ptr;
    for (int k = 1; k <= NUM_IN; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_IN) j = j - NUM_IN;
      if (!scan_v && in_v[SW'(j)]) begin
        scan_v   = 1'b1;
        scan_idx = SW'(j);
      end
    end
  end

  // Final grant: the burst hold wins, otherwise the round-robin scan result is used.
  always_comb begin
    gnt_v = hold || scan_v;
    gnt   = hold ? ptr : scan_idx;
  end

  // Select the granted source's word. in_d only reaches the capture register.
  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (gnt == SW'(i)) gnt_word = in_d[i*N +: N];
    end
  end

  // One-hot ack to the granted source. It is suppressed while reset is low or when the output cannot load.
  always_comb begin
    in_a = '0;
    if (reset && load && gnt_v) in_a[gnt] = 1'b1;
  end

  // Output stage and arbitration state. All of it holds while the decoder stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v   <= 1'b0;
      out_d   <= '0;
      out_src <= '0;
      ptr     <= PTR_RST;
      cnt     <= '0;
    end else if (load) begin
      if (gnt_v) begin
        out_v   <= 1'b1;
        out_d   <= gnt_word;
        out_src <= gnt;
        ptr     <= gnt;
        cnt     <= hold ? (cnt + 1'b1) : CNT_ONE;
      end else begin
        out_v <= 1'b0;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bd_word_arbiter.sv
// Bench for bd_word_arbiter. It builds two instances, with MAX_BURST=4 and
// MAX_BURST=1. It has a hand-derived vector table, directed sequences, and
// a randomized run checked against a source-queue reference model.
module tb_bd_word_arbiter;

  localparam int NUM_IN = 4;
  localparam int N      = 34;
  localparam int SW     = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance m occupies slice m of each packed bundle.
  logic [2*NUM_IN-1:0]   in_v_all;
  logic [2*NUM_IN*N-1:0] in_d_all;
  logic [2*NUM_IN-1:0]   in_a_all;
  logic [1:0]            out_v_all;
  logic [2*N-1:0]        out_d_all;
  logic [2*SW-1:0]       out_src_all;
  logic [1:0]            out_a_all;

  bd_word_arbiter #(.NUM_IN(NUM_IN), .N(N), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .in_v(in_v_all[0 +: NUM_IN]), .in_d(in_d_all[0 +: NUM_IN*N]),
    .in_a(in_a_all[0 +: NUM_IN]),
    .out_v(out_v_all[0]), .out_d(out_d_all[0 +: N]),
    .out_src(out_src_all[0 +: SW]), .out_a(out_a_all[0])
  );

  bd_word_arbiter #(.NUM_IN(NUM_IN), .N(N), .MAX_BURST(1)) dut_mb1 (
    .clk(clk), .reset(reset),
    .in_v(in_v_all[NUM_IN +: NUM_IN]), .in_d(in_d_all[NUM_IN*N +: NUM_IN*N]),
    .in_a(in_a_all[NUM_IN +: NUM_IN]),
    .out_v(out_v_all[1]), .out_d(out_d_all[N +: N]),
    .out_src(out_src_all[SW +: SW]), .out_a(out_a_all[1])
  );

  int total = 0;
  int bad   = 0;

  // Reference model state. Each source is a queue of pending words.
  logic [N-1:0] src_q[2][NUM_IN][$];
  logic [N-1:0] exp_q[2][$];
  bit           en[2][NUM_IN];
  int           seqn[2][NUM_IN];
  int           seen[2][NUM_IN];
  int           m_last[2];
  int           m_run[2];
  bit           m_ov[2];
  logic [N-1:0] m_od[2];
  int           m_os[2];

  function automatic int mb(input int m);
    return (m == 0) ? 4 : 1;
  endfunction

  function automatic logic [N-1:0] mk_word(input int m, input int i, input int s);
    logic [63:0] w;
    w = (64'(m) << 33) | (64'(i) << 28) | (64'(s) & 64'h0FFF_FFFF);
    return w[N-1:0];
  endfunction

  function automatic logic [N-1:0] cword(input int i);
    logic [63:0] w;
    w = 64'h2_A5A5_0000 + 64'(i) * 64'h1_0101;
    return w[N-1:0];
  endfunction

  function automatic logic [NUM_IN-1:0] get_in_a(input int m);
    return in_a_all[m*NUM_IN +: NUM_IN];
  endfunction
  function automatic logic [N-1:0] get_out_d(input int m);
    return out_d_all[m*N +: N];
  endfunction
  function automatic logic [SW-1:0] get_out_src(input int m);
    return out_src_all[m*SW +: SW];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int m);
    m_last[m] = NUM_IN - 1;
    m_run[m]  = 0;
    m_ov[m]   = 0;
    m_od[m]   = '0;
    m_os[m]   = 0;
    exp_q[m].delete();
  endtask

  task automatic clear_sources();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        src_q[m][i].delete();
        en[m][i]   = 0;
        seqn[m][i] = 0;
        seen[m][i] = 0;
      end
    end
  endtask

  task automatic add_words(input int m, input int i, input int n);
    for (int k = 0; k < n; k++) begin
      src_q[m][i].push_back(mk_word(m, i, seqn[m][i]));
      seqn[m][i]++;
    end
  endtask

  // Spec-level grant: keep the burst owner under the limit, else the first valid source after it.
  function automatic int model_grant(input int m, input logic [NUM_IN-1:0] v,
                                     output bit found, output bit is_hold);
    int s;
    found   = 0;
    is_hold = 0;
    if (m_run[m] > 0 && m_run[m] < mb(m) && v[m_last[m]]) begin
      found   = 1;
      is_hold = 1;
      return m_last[m];
    end
    for (int k = 1; k <= NUM_IN; k++) begin
      s = (m_last[m] + k) % NUM_IN;
      if (v[s]) begin
        found = 1;
        return s;
      end
    end
    return 0;
  endfunction

  task automatic drive_inputs();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        in_v_all[m*NUM_IN + i] = en[m][i] && (src_q[m][i].size() > 0);
        in_d_all[(m*NUM_IN + i)*N +: N] = (src_q[m][i].size() > 0) ? src_q[m][i][0] : '0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One model-checked cycle. It is entered and left at a negedge.
  task automatic tick();
    bit           gv[2];
    bit           hd[2];
    bit           ld[2];
    int           g[2];
    logic [NUM_IN-1:0] ea;
    logic [N-1:0] w;
    drive_inputs();
    #2;
    for (int m = 0; m < 2; m++) begin
      g[m]  = model_grant(m, in_v_all[m*NUM_IN +: NUM_IN], gv[m], hd[m]);
      ld[m] = !m_ov[m] || out_a_all[m];
      ea = '0;
      if (ld[m] && gv[m]) ea[g[m]] = 1'b1;
      chk($sformatf("in_a inst%0d", m), 64'(get_in_a(m)), 64'(ea));
      if (out_v_all[m] && out_a_all[m]) begin
        seen[m][get_out_src(m)]++;
        if (exp_q[m].size() == 0) chk($sformatf("sb underflow inst%0d", m), 1, 0);
        else begin
          w = exp_q[m].pop_front();
          chk($sformatf("sb word inst%0d", m), 64'(get_out_d(m)), 64'(w));
        end
      end
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (ld[m]) begin
        if (gv[m]) begin
          w = src_q[m][g[m]].pop_front();
          exp_q[m].push_back(w);
          m_od[m]   = w;
          m_os[m]   = g[m];
          m_ov[m]   = 1;
          m_run[m]  = hd[m] ? m_run[m] + 1 : 1;
          m_last[m] = g[m];
        end else begin
          m_ov[m]  = 0;
          m_run[m] = 0;
        end
      end
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("out_v inst%0d", m), 64'(out_v_all[m]), 64'(m_ov[m]));
      chk($sformatf("out_src inst%0d", m), 64'(get_out_src(m)), 64'(m_os[m]));
      chk($sformatf("out_d inst%0d", m), 64'(get_out_d(m)), 64'(m_od[m]));
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [NUM_IN-1:0] v;
    logic              oa;
    logic [NUM_IN-1:0] ea;
    logic              ev;
    int                es;
    bit                dz;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[12];
    logic [N-1:0] dv[6];
    logic [N-1:0] held;
    int           e2[7];

    // Hand-derived vectors for instance 0 (MAX_BURST=4). Each source drives a constant word.
    tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 1'b1};
    tbl[1]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2, 1'b0};
    tbl[2]  = '{4'b0110, 1'b0, 4'b0000, 1'b1, 2, 1'b0};
    tbl[3]  = '{4'b0110, 1'b1, 4'b0100, 1'b1, 2, 1'b0};
    tbl[4]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 1, 1'b0};
    tbl[5]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1, 1'b0};
    tbl[6]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1, 1'b0};
    tbl[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1, 1'b0};
    tbl[8]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 3, 1'b0};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 3, 1'b0};
    tbl[10] = '{4'b0001, 1'b0, 4'b0001, 1'b1, 0, 1'b0};
    tbl[11] = '{4'b0001, 1'b0, 4'b0000, 1'b1, 0, 1'b0};

    // Clock/reset block: hold reset with every source valid and check that no ack leaks out.
    reset     = 1'b0;
    in_v_all  = '1;
    in_d_all  = '0;
    out_a_all = 2'b11;
    clear_sources();
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    #1;
    chk("reset out_v", 64'(out_v_all), 64'(0));
    chk("reset out_d", 64'(out_d_all), 64'(0));
    chk("reset out_src", 64'(out_src_all), 64'(0));
    chk("reset in_a", 64'(in_a_all), 64'(0));
    @(negedge clk);
    in_v_all = '0;
    reset    = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < NUM_IN; i++) in_d_all[i*N +: N] = cword(i);
    for (int r = 0; r < 12; r++) begin
      in_v_all[0 +: NUM_IN] = tbl[r].v;
      out_a_all[0]          = tbl[r].oa;
      #2;
      chk($sformatf("tbl%0d in_a", r), 64'(get_in_a(0)), 64'(tbl[r].ea));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d out_v", r), 64'(out_v_all[0]), 64'(tbl[r].ev));
      chk($sformatf("tbl%0d out_src", r), 64'(get_out_src(0)), 64'(tbl[r].es));
      chk($sformatf("tbl%0d out_d", r), 64'(get_out_d(0)),
          tbl[r].dz ? 64'(0) : 64'(cword(tbl[r].es)));
      @(negedge clk);
    end

    // Lone source 2 streams six words back to back, including the re-grant at the burst end.
    clear_sources();
    do_reset();
    out_a_all = 2'b11;
    add_words(0, 2, 6);
    for (int k = 0; k < 6; k++) dv[k] = src_q[0][2][k];
    en[0][2] = 1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("lone out_v %0d", k), 64'(out_v_all[0]), 64'(1));
      chk($sformatf("lone out_d %0d", k), 64'(get_out_d(0)), 64'(dv[k]));
      chk($sformatf("lone out_src %0d", k), 64'(get_out_src(0)), 64'(2));
    end
    tick();
    chk("lone drained out_v", 64'(out_v_all[0]), 64'(0));

    // All sources always valid: bursts of 4 on instance 0, strict alternation on instance 1.
    clear_sources();
    do_reset();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NUM_IN; i++) begin
        add_words(m, i, 8);
        en[m][i] = 1;
      end
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("rr4 src %0d", k), 64'(get_out_src(0)), 64'((k / 4) % 4));
      chk($sformatf("rr1 src %0d", k), 64'(get_out_src(1)), 64'(k % 4));
    end

    // MAX_BURST=1 with sources 0 and 3: alternation and per-source word counts.
    clear_sources();
    do_reset();
    add_words(1, 0, 6);
    add_words(1, 3, 6);
    en[1][0] = 1;
    en[1][3] = 1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("alt src %0d", k), 64'(get_out_src(1)), (k % 2 == 0) ? 64'(0) : 64'(3));
    end
    tick();
    chk("alt drained out_v", 64'(out_v_all[1]), 64'(0));
    chk("alt seen src0", 64'(seen[1][0]), 64'(6));
    chk("alt seen src3", 64'(seen[1][3]), 64'(6));

    // Decoder stall: the output holds and every ack stays low; the next word follows on release.
    clear_sources();
    do_reset();
    add_words(0, 0, 8);
    en[0][0] = 1;
    tick();
    tick();
    held = mk_word(0, 0, 1);
    out_a_all[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall out_d %0d", k), 64'(get_out_d(0)), 64'(held));
      chk($sformatf("stall out_v %0d", k), 64'(out_v_all[0]), 64'(1));
      chk($sformatf("stall in_a %0d", k), 64'(get_in_a(0)), 64'(0));
    end
    out_a_all[0] = 1'b1;
    tick();
    chk("stall release out_d", 64'(get_out_d(0)), 64'(mk_word(0, 0, 2)));

    // Source 1 drops valid mid-burst: source 2 takes over with a fresh burst of four.
    clear_sources();
    do_reset();
    add_words(0, 1, 6);
    add_words(0, 2, 6);
    en[0][2] = 1;
    e2 = '{1, 1, 2, 2, 2, 2, 1};
    for (int k = 0; k < 7; k++) begin
      en[0][1] = (k != 2);
      tick();
      chk($sformatf("drop src %0d", k), 64'(get_out_src(0)), 64'(e2[k]));
    end

    // Asynchronous reset while a word is held: out_v falls at once, then grants restart from source 0.
    #2;
    reset = 1'b0;
    #1;
    chk("async out_v", 64'(out_v_all[0]), 64'(0));
    chk("async in_a", 64'(in_a_all), 64'(0));
    chk("async out_src", 64'(get_out_src(0)), 64'(0));
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    reset = 1'b1;
    add_words(0, 3, 2);
    en[0][3] = 1;
    tick();
    chk("restart src", 64'(get_out_src(0)), 64'(1));

    // Randomized traffic on both instances against the model, with occasional resets.
    clear_sources();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < 2; m++) begin
        for (int i = 0; i < NUM_IN; i++) begin
          en[m][i] = ($urandom_range(0, 3) != 0);
          if (src_q[m][i].size() < 3 && $urandom_range(0, 3) == 0)
            add_words(m, i, $urandom_range(1, 6));
        end
        out_a_all[m] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
